// File: rtl/csr_arbiter_if.sv
// csr_arbiter_if: bundles both requesting masters' handshakes, the shared CSR bus and
// the busy flag. The arbiter connects through the slave modport. The master modport
// is the environment side: both masters plus the CSR slaves' read data.
interface csr_arbiter_if #(
    parameter int unsigned AW = 14,
    parameter int unsigned DW = 32
);
    // Master 0 (CPU-side CSR bridge)
    logic          m0_stb;
    logic          m0_we;
    logic [AW-1:0] m0_a;
    logic [DW-1:0] m0_di;
    logic [DW-1:0] m0_do;
    logic          m0_ack;

    // Master 1 (debug/DMA side)
    logic          m1_stb;
    logic          m1_we;
    logic [AW-1:0] m1_a;
    logic [DW-1:0] m1_di;
    logic [DW-1:0] m1_do;
    logic          m1_ack;

    // Shared CSR bus
    logic [AW-1:0] csr_a;
    logic          csr_we;
    logic [DW-1:0] csr_di;
    logic [DW-1:0] csr_do;

    logic          busy;

    modport slave (
        input  m0_stb, m0_we, m0_a, m0_di,
        output m0_do, m0_ack,
        input  m1_stb, m1_we, m1_a, m1_di,
        output m1_do, m1_ack,
        output csr_a, csr_we, csr_di,
        input  csr_do,
        output busy
    );

    modport master (
        output m0_stb, m0_we, m0_a, m0_di,
        input  m0_do, m0_ack,
        output m1_stb, m1_we, m1_a, m1_di,
        input  m1_do, m1_ack,
        input  csr_a, csr_we, csr_di,
        output csr_do,
        input  busy
    );
endinterface

// File: rtl/csr_arbiter.sv
// csr_arbiter: shares the single CSR bus between two masters, one transaction at a time.
// Each transaction takes IDLE -> ISSUE -> WAIT. The extra WAIT cycle covers the slaves'
// registered read data. Ties are broken round-robin against the last granted master.
module csr_arbiter #(
    parameter int unsigned AW = 14,
    parameter int unsigned DW = 32
) (
    input logic          sys_clk,
    input logic          sys_rst_n,
    csr_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e        state_q;
    logic          gnt_q;     // master owning the transaction in flight
    logic          last_q;    // most recently granted master, used for tie-breaks
    logic [AW-1:0] csr_a_q;
    logic          csr_we_q;
    logic [DW-1:0] csr_di_q;
    logic [DW-1:0] m0_do_q;
    logic [DW-1:0] m1_do_q;
    logic          m0_ack_q;
    logic          m1_ack_q;
    logic          busy_q;

    logic          elig0;
    logic          elig1;
    logic          req_any;
    logic          pick;
    logic [AW-1:0] sel_a;
    logic          sel_we;
    logic [DW-1:0] sel_di;

    // Eligibility, round-robin choice and the granted master's request fields.
    always_comb begin
        // A strobe seen together with its own ack is the tail of the finished
        // transaction, not a new request.
        elig0   = bus.m0_stb & ~m0_ack_q;
        elig1   = bus.m1_stb & ~m1_ack_q;
        req_any = elig0 | elig1;
        if (elig0 && elig1) begin
            pick = ~last_q;
        end else begin
            pick = elig1;
        end
        if (pick) begin
            sel_a  = bus.m1_a;
            sel_we = bus.m1_we;
            sel_di = bus.m1_di;
        end else begin
            sel_a  = bus.m0_a;
            sel_we = bus.m0_we;
            sel_di = bus.m0_di;
        end
    end

    // Transaction FSM with all bus, ack and read-data outputs registered.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q  <= StIdle;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            csr_a_q  <= '0;
            csr_we_q <= 1'b0;
            csr_di_q <= '0;
            m0_do_q  <= '0;
            m1_do_q  <= '0;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // Acks are single-cycle pulses; only WAIT raises one.
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_any) begin
                        gnt_q    <= pick;
                        last_q   <= pick;
                        csr_a_q  <= sel_a;
                        csr_we_q <= sel_we;
                        csr_di_q <= sel_di;
                        busy_q   <= 1'b1;
                        state_q  <= StIssue;
                    end
                end
                StIssue: begin
                    // Slaves sample the bus at the end of ISSUE, so it returns to 0
                    // here and a write strobe lasts exactly one cycle.
                    csr_a_q  <= '0;
                    csr_we_q <= 1'b0;
                    csr_di_q <= '0;
                    state_q  <= StWait;
                end
                StWait: begin
                    // Read data is captured for writes as well. Masters ignore it.
                    if (gnt_q) begin
                        m1_do_q  <= bus.csr_do;
                        m1_ack_q <= 1'b1;
                    end else begin
                        m0_do_q  <= bus.csr_do;
                        m0_ack_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.csr_a  = csr_a_q;
    assign bus.csr_we = csr_we_q;
    assign bus.csr_di = csr_di_q;
    assign bus.m0_do  = m0_do_q;
    assign bus.m0_ack = m0_ack_q;
    assign bus.m1_do  = m1_do_q;
    assign bus.m1_ack = m1_ack_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_csr_arbiter.sv
// tb_csr_arbiter: table-driven single transactions, plus hand-written contention,
// fairness, held-strobe and reset-mid-transaction sequences. An ack scoreboard
// checks which master is acked and the read data it gets back.
module tb_csr_arbiter;
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    csr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    csr_arbiter #(.AW(AW), .DW(DW)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        bit          m;
        bit          we;
        logic [13:0] a;
        logic [31:0] di;
        logic [31:0] exp_do;
    } vec_t;

    typedef struct {
        bit          m;
        bit          we;
        logic [31:0] rdata;
    } rec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    rec_t        sb_q[$];
    logic [31:0] held_do[2];
    bit          held_ok[2];
    rec_t        mon_rec;
    bit          mon_m;

    // Slave model: read data depends on the address and is returned one cycle later.
    function automatic logic [31:0] rom(input logic [13:0] a);
        if (a == 14'h0005) return 32'hFFFF_FFFF;
        return {a, 18'h0} ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) bus.csr_do <= rom(bus.csr_a);

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input bit m, input bit stb, input bit we, input logic [13:0] a,
                           input logic [31:0] di);
        if (m) begin
            bus.m1_stb = stb; bus.m1_we = we; bus.m1_a = a; bus.m1_di = di;
        end else begin
            bus.m0_stb = stb; bus.m0_we = we; bus.m0_a = a; bus.m0_di = di;
        end
    endtask

    task automatic push(input bit m, input bit we, input logic [31:0] rdata);
        rec_t r;
        r.m = m; r.we = we; r.rdata = rdata;
        sb_q.push_back(r);
    endtask

    // Advance until master m acks; cyc counts cycles from the caller's reference.
    task automatic wait_ack(input bit m, input int start, output int cyc);
        cyc = start;
        do begin
            tick();
            cyc++;
        end while (!(m ? bus.m1_ack : bus.m0_ack) && cyc < 12);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        check("rst_ctrl", {bus.busy, bus.m0_ack, bus.m1_ack, bus.csr_we, bus.csr_a}, '0);
        check("rst_csr_di", bus.csr_di, '0);
        check("rst_do", {bus.m0_do, bus.m1_do}, '0);
        for (int i = 0; i < 2; i++) begin
            held_do[i] = '0;
            held_ok[i] = 1'b1;
        end
        rst_n = 1'b1;
    endtask

    // One complete transaction from a single master, checking every phase.
    task automatic do_txn(input bit m, input bit we, input logic [13:0] a,
                          input logic [31:0] di, input logic [31:0] exp_do);
        int cyc;
        set_req(m, 1'b1, we, a, di);
        push(m, we, exp_do);
        tick();
        check("issue_busy", bus.busy, 1);
        check("issue_a", bus.csr_a, a);
        check("issue_we", bus.csr_we, we);
        check("issue_di", bus.csr_di, di);
        tick();
        check("wait_bus_idle", {bus.csr_we, bus.csr_a, bus.csr_di}, '0);
        check("wait_busy", bus.busy, 1);
        wait_ack(m, 2, cyc);
        check("ack_latency", cyc, 3);
        set_req(m, 1'b0, 1'b0, '0, '0);
        tick();
        check("ack_pulse", {bus.m0_ack, bus.m1_ack}, '0);
        check("idle_busy", bus.busy, 0);
    endtask

    // Ack scoreboard: pops one expected record per ack, in order.
    always @(negedge clk) begin
        if (bus.m0_ack || bus.m1_ack) begin
            check("ack_exclusive", bus.m0_ack & bus.m1_ack, 0);
            mon_m = bus.m1_ack;
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack from m%0d, want none", mon_m);
            end else begin
                mon_rec = sb_q.pop_front();
                check("ack_master", mon_m, mon_rec.m);
                if (!mon_rec.we)
                    check("read_data", mon_m ? bus.m1_do : bus.m0_do, mon_rec.rdata);
                if (held_ok[!mon_m])
                    check("other_do_held", mon_m ? bus.m0_do : bus.m1_do, held_do[!mon_m]);
                held_ok[mon_m] = !mon_rec.we;
                held_do[mon_m] = mon_rec.rdata;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   cyc;
        int   cnt[2];
        int   total;
        bit   want_m;
        bit   busy_seen;

        vecs[0] = '{m: 1'b0, we: 1'b0, a: 14'h0005, di: 32'h0,         exp_do: 32'hFFFF_FFFF};
        vecs[1] = '{m: 1'b1, we: 1'b1, a: 14'h0006, di: 32'h1234_5678, exp_do: 32'h0};
        vecs[2] = '{m: 1'b1, we: 1'b0, a: 14'h0123, di: 32'h0,         exp_do: rom(14'h0123)};
        vecs[3] = '{m: 1'b0, we: 1'b1, a: 14'h3FFF, di: 32'hDEAD_BEEF, exp_do: 32'h0};
        vecs[4] = '{m: 1'b0, we: 1'b0, a: 14'h3FFF, di: 32'h0,         exp_do: rom(14'h3FFF)};
        vecs[5] = '{m: 1'b1, we: 1'b0, a: 14'h0000, di: 32'h0,         exp_do: rom(14'h0000)};
        vecs[6] = '{m: 1'b0, we: 1'b1, a: 14'h0001, di: 32'h0000_0000, exp_do: 32'h0};
        vecs[7] = '{m: 1'b1, we: 1'b0, a: 14'h2AAA, di: 32'h0,         exp_do: rom(14'h2AAA)};

        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        do_reset();
        tick();

        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].m, vecs[i].we, vecs[i].a, vecs[i].di, vecs[i].exp_do);
        end

        // Contention straight after reset: m0 first, m1 granted in m0's ack cycle.
        do_reset();
        set_req(1'b0, 1'b1, 1'b0, 14'h0010, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 14'h0020, 32'h0);
        push(1'b0, 1'b0, rom(14'h0010));
        push(1'b1, 1'b0, rom(14'h0020));
        tick();
        check("tie_first_m0", bus.csr_a, 14'h0010);
        wait_ack(1'b0, 1, cyc);
        check("tie_m0_latency", cyc, 3);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        check("tie_m1_in_ack_cycle", {bus.busy, bus.csr_a}, {1'b1, 14'h0020});
        wait_ack(1'b1, 1, cyc);
        check("tie_m1_latency", cyc, 3);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        tick();

        // Solo m0 makes m0 the last grant, so the next tie goes to m1.
        do_txn(1'b0, 1'b0, 14'h0030, 32'h0, rom(14'h0030));
        set_req(1'b0, 1'b1, 1'b0, 14'h0040, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 14'h0050, 32'h0);
        push(1'b1, 1'b0, rom(14'h0050));
        push(1'b0, 1'b0, rom(14'h0040));
        tick();
        check("tie_second_m1", bus.csr_a, 14'h0050);
        wait_ack(1'b1, 1, cyc);
        check("tie_second_m1_latency", cyc, 3);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        wait_ack(1'b0, 0, cyc);
        check("tie_second_m0_latency", cyc, 3);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        tick();

        // Fairness: both masters request continuously, 10 transactions each.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            push(i[0], 1'b0, rom(i[0] ? 14'h0200 + 14'(i / 2) : 14'h0100 + 14'(i / 2)));
        end
        cnt[0] = 0;
        cnt[1] = 0;
        total  = 0;
        want_m = 1'b0;
        cyc    = 0;
        set_req(1'b0, 1'b1, 1'b0, 14'h0100, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 14'h0200, 32'h0);
        while (total < 20 && cyc < 90) begin
            tick();
            cyc++;
            if (bus.m0_ack || bus.m1_ack) begin
                check("fair_alternate", bus.m1_ack, want_m);
                cnt[bus.m1_ack]++;
                total++;
                want_m = !bus.m1_ack;
                set_req(1'b0, cnt[0] < 10, 1'b0, 14'h0100 + 14'(cnt[0]), 32'h0);
                set_req(1'b1, cnt[1] < 10, 1'b0, 14'h0200 + 14'(cnt[1]), 32'h0);
            end
        end
        check("fair_total_acks", total, 20);
        check("fair_cycles", cyc, 60);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        tick();

        // Strobe held through the ack cycle must not start a second transaction.
        set_req(1'b0, 1'b1, 1'b0, 14'h0044, 32'h0);
        push(1'b0, 1'b0, rom(14'h0044));
        wait_ack(1'b0, 0, cyc);
        check("held_latency", cyc, 3);
        tick();
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        check("held_no_reissue", bus.busy, 0);
        busy_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            busy_seen |= bus.busy;
        end
        check("held_bus_quiet", busy_seen, 0);

        // Reset during ISSUE of a write: no ack, everything back to 0.
        set_req(1'b1, 1'b1, 1'b1, 14'h0077, 32'hCAFE_F00D);
        tick();
        check("rstmid_issue_we", {bus.csr_we, bus.csr_a}, {1'b1, 14'h0077});
        rst_n = 1'b0;
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        check("rstmid_cleared", {bus.busy, bus.csr_we, bus.csr_a, bus.m0_ack, bus.m1_ack}, '0);
        check("rstmid_csr_di", bus.csr_di, '0);
        for (int i = 0; i < 2; i++) begin
            held_do[i] = '0;
            held_ok[i] = 1'b1;
        end
        rst_n = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            busy_seen |= bus.busy | bus.m0_ack | bus.m1_ack;
        end
        check("rstmid_stays_idle", busy_seen, 0);
        do_txn(1'b0, 1'b0, 14'h0009, 32'h0, rom(14'h0009));

        tick();
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_arbiter.md
# csr_arbiter

Two-master arbiter that shares the single CSR bus between the CPU-side CSR bridge (master 0) and the debug/DMA-side master (master 1). It places one transaction at a time onto the CSR bus that feeds the system-control, GPIO/timer and other CSR slaves. It accounts for the bus's one-cycle registered read latency and returns read data with a one-cycle acknowledge pulse to the requester. Ties are resolved round-robin, so neither master can starve the other.

## Interface
- `AW`, 14: CSR address width, matching the CSR bus.
- `DW`, 32: CSR data width.
- `sys_clk` in 1: system clock; all logic is on the rising edge.
- `sys_rst_n` in 1: reset, synchronous, active-low.
- `m0_stb` in 1: master 0 request. Held with `m0_a`/`m0_we`/`m0_di` stable until `m0_ack`.
- `m0_we` in 1: master 0 write enable (1 = write, 0 = read).
- `m0_a` in AW: master 0 address.
- `m0_di` in DW: master 0 write data.
- `m0_do` out DW: master 0 read data. Valid while `m0_ack`=1.
- `m0_ack` out 1: master 0 completion, a one-cycle pulse.
- `m1_stb`, `m1_we`, `m1_a`, `m1_di`, `m1_do`, `m1_ack`: same as master 0, for master 1.
- `csr_a` out AW: CSR bus address, registered.
- `csr_we` out 1: CSR bus write strobe, registered.
- `csr_di` out DW: CSR bus write data, registered.
- `csr_do` in DW: CSR bus read data, OR of all slaves. Registered by the slaves, so valid one cycle after the address.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Reset values: all outputs 0, state IDLE, `last` = 1 (master 0 wins the first tie).
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - Eligible request for master n: `mn_stb` & ~`mn_ack`. A master's strobe is ignored in the cycle its ack is high; this prevents a double issue before the master drops `stb`.
  - If exactly one master is eligible, grant it.
  - If both are eligible, grant the master != `last`.
  - On a grant: latch `gnt`, set `last` <= gnt, load `csr_a`/`csr_we`/`csr_di` from the granted master, and go to ISSUE.
  - With no eligible request, `csr_a`, `csr_we` and `csr_di` stay 0.
- **ISSUE**
  - Bus fields are valid for exactly this cycle; the slave samples them at the end of the cycle.
  - Next state WAIT. In the same transition `csr_we` <= 0, `csr_a` <= 0 and `csr_di` <= 0.
- **WAIT**
  - `csr_do` is valid this cycle.
  - At the end of the cycle: `m<gnt>_do` <= `csr_do`, `m<gnt>_ack` <= 1, next state IDLE.
  - The read data is captured for writes too; the value is don't-care and masters ignore it.
- Acks are high for exactly one cycle. The non-granted master's `mn_do` holds its previous value.
- `mn_do` holds its last captured value until that master's next ack.
- A master that drops `stb` after being granted still receives its ack. Masters must not do this.
- `csr_we` is high for at most one cycle per write transaction. It is never high in IDLE or WAIT.

## Timing
- Master request first seen high at edge T in IDLE:
  - `csr_*` driven in cycle T+1 (ISSUE).
  - State WAIT in cycle T+2.
  - `ack` and `do` valid in cycle T+3, with the FSM back in IDLE.
- Latency from request to ack: 3 cycles.
- Peak throughput: one transaction every 3 cycles.
  - Back-to-back from one master: next `stb` seen in cycle T+4, which is the IDLE cycle after the ack.
  - Alternating masters: the other master is granted in cycle T+3, the IDLE cycle in which the first master's ack is high.
- Reset asserted mid-transaction:
  - FSM returns to IDLE, no ack is issued, and all outputs go to 0 on the next edge.
  - The pending bus write was either already issued or is dropped entirely; it is never partial.

## Test plan
- Single read: `m0` reads address 0x0005 while the slave model returns 0xFFFFFFFF.
  - Required: `csr_a`=0x0005 and `csr_we`=0 for one cycle.
  - Required: `m0_ack` pulses 3 cycles after `stb` with `m0_do`=0xFFFFFFFF; `m1_ack` stays 0.
- Single write: `m1` writes 0x12345678 to address 0x0006.
  - Required: exactly one cycle with `csr_we`=1, `csr_a`=0x0006, `csr_di`=0x12345678.
  - Required: `m1_ack` pulses once.
- Contention: `m0` and `m1` both raise `stb` in the same cycle after reset.
  - Required: `m0` is granted first and `m1` is issued in the IDLE cycle where `m0_ack`=1.
  - On the next simultaneous pair, `m1` wins.
- Starvation check: both masters issue 10 requests each continuously.
  - Required: grants strictly alternate and 20 acks arrive in 60 cycles.
- Held strobe: `m0` keeps `stb` high one cycle past its ack.
  - Required: only one bus transaction occurs and only one `m0_ack`.
- Reset mid-op: assert `sys_rst_n`=0 during ISSUE of a write.
  - Required: no ack; `busy`, `csr_we`, `csr_a`=0 after the edge.
  - Required: the FSM accepts a new request normally after reset is released.
